// File: rtl/timestep_sequencer.sv
// Timestep sequencer: debounces the Peel button into single steps of the 2-bit
// controller timestep T, tracks completed instructions and flags wrap overruns.
// Optional auto-run stepping is compiled in with `define AUTO_RUN_EN.
module timestep_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       peel,
    input  logic       clr,
    input  logic       run,
    output logic [1:0] T,
    output logic       step_pulse,
    output logic       inst_done,
    output logic [7:0] inst_count,
    output logic       busy,
    output logic       overrun
);

    localparam int              CNT_W    = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } db_state_t;

    logic             peel_meta;
    logic             peel_s;
    db_state_t        db_state;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_step;
    logic             run_tick;
    logic             step;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peel_meta <= 1'b0;
            peel_s    <= 1'b0;
        end else begin
            peel_meta <= peel;
            peel_s    <= peel_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_state <= RELEASED;
            db_cnt   <= '0;
        end else begin
            case (db_state)
                RELEASED: begin
                    if (peel_s) begin
                        db_state <= PRESS_CHK;
                        db_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!peel_s)                db_state <= RELEASED;
                    else if (db_cnt == CNT_LAST) db_state <= PRESSED;
                    else                        db_cnt   <= db_cnt + CNT_W'(1);
                end
                PRESSED: begin
                    if (!peel_s) begin
                        db_state <= RELEASE_CHK;
                        db_cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (peel_s)                 db_state <= PRESSED;
                    else if (db_cnt == CNT_LAST) db_state <= RELEASED;
                    else                        db_cnt   <= db_cnt + CNT_W'(1);
                end
                default: db_state <= RELEASED;
            endcase
        end
    end

    // NOTE: btn_step is decoded from the FSM's current state rather than registered,
    // so it fires in the same cycle the count completes; step_pulse adds the one
    // register stage in front of the T update.
    assign btn_step = (db_state == PRESS_CHK) && peel_s && (db_cnt == CNT_LAST);

`ifdef AUTO_RUN_EN
    localparam int               RUN_W    = $clog2(RUN_DIV);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

    logic             run_meta;
    logic             run_s;
    logic [RUN_W-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            run_cnt  <= '0;
        end else begin
            run_meta <= run;
            run_s    <= run_meta;
            if (!run_s || run_cnt == RUN_LAST) run_cnt <= '0;
            else                               run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    assign run_tick = run_s && (run_cnt == RUN_LAST);
`else
    logic unused_run;
    assign unused_run = run;
    assign run_tick   = 1'b0;
`endif

    // A press landing on an auto-run tick merges into a single step.
    assign step = btn_step | run_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pulse <= 1'b0;
            inst_done  <= 1'b0;
            T          <= 2'd0;
            inst_count <= 8'd0;
            overrun    <= 1'b0;
        end else begin
            step_pulse <= step;
            inst_done  <= 1'b0;
            if (step_pulse) begin
                if (clr) begin
                    T          <= 2'd0;
                    inst_done  <= 1'b1;
                    inst_count <= inst_count + 8'd1;
                end else if (T == 2'd3) begin
                    T       <= 2'd0;
                    overrun <= 1'b1;
                end else begin
                    T <= T + 2'd1;
                end
            end
        end
    end

    assign busy = (T != 2'd0);

endmodule

// File: tb/tb_timestep_sequencer.sv
// Scoreboard bench for timestep_sequencer: stimulus pushes the model's expected
// post-step state; a negedge monitor pops and compares on every step_pulse.
module tb_timestep_sequencer;

    localparam int DB = 4;
    localparam int RD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       peel = 1'b0;
    logic       clr_drv = 1'b0;
    logic       auto_clr = 1'b0;
    logic       run = 1'b0;
    logic       clr;
    logic [1:0] T;
    logic       step_pulse;
    logic       inst_done;
    logic [7:0] inst_count;
    logic       busy;
    logic       overrun;

    // During auto-run the bench behaves like the controller: Clr decodes T == 2.
    assign clr = auto_clr ? (T == 2'd2) : clr_drv;

    timestep_sequencer #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .peel       (peel),
        .clr        (clr),
        .run        (run),
        .T          (T),
        .step_pulse (step_pulse),
        .inst_done  (inst_done),
        .inst_count (inst_count),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] t;
        logic       done;
        logic [7:0] count;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pend = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    int m_t = 0;
    int m_count = 0;
    bit m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One instruction step as the controller sees it.
    function automatic void model_step(input bit c);
        exp_t e;
        if (c) begin
            m_t     = 0;
            m_count = (m_count + 1) % 256;
            e.done  = 1'b1;
        end else begin
            e.done = 1'b0;
            if (m_t == 3) begin
                m_t   = 0;
                m_ovr = 1'b1;
            end else begin
                m_t = m_t + 1;
            end
        end
        e.t     = 2'(m_t);
        e.count = 8'(m_count);
        e.ovr   = m_ovr;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_t     = 0;
        m_count = 0;
        m_ovr   = 1'b0;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Clean press with optional release bounce; the step lands during hold/release.
    task automatic press(input bit c, input int hold, input int nbounce);
        clr_drv = c;
        model_step(c);
        peel = 1'b1;
        cycles(hold);
        for (int i = 0; i < nbounce; i++) begin
            peel = 1'b0;
            cycles(int'($urandom_range(3, 1)));
            peel = 1'b1;
            cycles(int'($urandom_range(3, 1)));
        end
        peel = 1'b0;
        cycles(DB + 3);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_t"},          32'(T),          32'd0);
        check({tag, "_step_pulse"}, 32'(step_pulse), 32'd0);
        check({tag, "_inst_done"},  32'(inst_done),  32'd0);
        check({tag, "_inst_count"}, 32'(inst_count), 32'd0);
        check({tag, "_overrun"},    32'(overrun),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Monitor: compare the cycle after each step_pulse, flag stray steps.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("step_t",          32'(T),          32'(cur.t));
                    check("step_inst_done",  32'(inst_done),  32'(cur.done));
                    check("step_inst_count", 32'(inst_count), 32'(cur.count));
                    check("step_overrun",    32'(overrun),    32'(cur.ovr));
                    check("step_busy",       32'(busy),       32'(cur.t != 2'd0));
                end else begin
                    check("inst_done_idle", 32'(inst_done), 32'd0);
                end
                pend = 1'b0;
                if (step_pulse) begin
                    check("step_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        cur  = exp_q.pop_front();
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n_wrap;

        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        rst_n = 1'b1;
        cycles(5);

        // Short glitches never reach the debounce threshold.
        for (int i = 0; i < 3; i++) begin
            peel = 1'b1;
            cycles(2);
            peel = 1'b0;
            cycles(4);
        end
        cycles(10);
        check("glitch_t", 32'(T), 32'd0);

        // Clean 20-cycle press, 20-cycle release.
        clr_drv = 1'b0;
        model_step(1'b0);
        peel = 1'b1;
        cycles(20);
        peel = 1'b0;
        cycles(20);
        check("press_t", 32'(T), 32'd1);

        // clr only when T == 3: 2, 3, then completed instruction.
        for (int i = 0; i < 3; i++) press(m_t == 3, 20, 0);
        check("clr3_t",          32'(T),          32'd0);
        check("clr3_inst_count", 32'(inst_count), 32'd1);
        check("clr3_overrun",    32'(overrun),    32'd0);

        // clr never asserted: 1, 2, 3, wrap with overrun.
        for (int i = 0; i < 4; i++) press(1'b0, int'($urandom_range(10, DB + 2)), 2);
        check("ovr_t",          32'(T),          32'd0);
        check("ovr_overrun",    32'(overrun),    32'd1);
        check("ovr_inst_count", 32'(inst_count), 32'd1);

        // Leave T busy, then reset asynchronously part-way through a press.
        press(1'b0, 8, 1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        clr_drv = 1'b0;
        peel = 1'b1;
        cycles(3);
        #1 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        peel = 1'b0;
        cycles(3);
        check("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_reset();
        rst_n = 1'b1;
        cycles(12);
        check("post_reset_t", 32'(T), 32'd0);

        // Auto-run for 64 clocks with the controller clearing at T == 2.
`ifdef AUTO_RUN_EN
        for (int i = 0; i < 64 / RD; i++) model_step(m_t == 2);
`endif
        auto_clr = 1'b1;
        run = 1'b1;
        cycles(64);
        run = 1'b0;
        cycles(10);
        auto_clr = 1'b0;
        check("auto_t",          32'(T),          32'(m_t));
        check("auto_inst_count", 32'(inst_count), 32'(m_count));

        // Randomised presses and Clr decisions.
        for (int i = 0; i < 40; i++)
            press(1'($urandom_range(1, 0)), int'($urandom_range(14, DB + 2)),
                  int'($urandom_range(3, 0)));
        check("rand_overrun", 32'(overrun), 32'(m_ovr));

        // Drive inst_count through 255 and wrap it to 0.
        n_wrap = 256 - m_count;
        for (int i = 0; i < n_wrap; i++) begin
            press(1'b1, DB + 2, 0);
            if (m_count == 255) check("count_at_255", 32'(inst_count), 32'd255);
        end
        check("count_wrap", 32'(inst_count), 32'd0);

`ifdef AUTO_RUN_EN
        // Press timed so its debounce completes on the first run tick: one step.
        clr_drv = 1'b0;
        model_step(1'b0);
        run = 1'b1;
        cycles(RD - 1 - DB);
        peel = 1'b1;
        cycles(DB + 1);
        run = 1'b0;
        cycles(15);
        peel = 1'b0;
        cycles(12);
        check("coincident_t", 32'(T), 32'(m_t));
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycles(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_t", 32'(T), 32'(m_t));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
